cc_game_controller: RTL and testbench
=====================================

Name: cc_game_controller

Overview:
- Downstream of the collision detector. Consumes its active-low collision flag once per game step.
- Runs the round state machine: idle, play, hit-freeze, game over.
- Keeps the lives and score counters.
- Drives the run enable and clear pulse back to the background/point generators that feed the detector.

Parameters:
- LIVES_INIT, 3, lives loaded on round start; range 1..2^LIVES_WIDTH-1
- LIVES_WIDTH, 2, width of the lives counter
- SCORE_WIDTH, 8, width of the score counter
- HIT_TICKS, 4, game ticks frozen after a non-fatal hit; must be >=1

Ports:
- CC_GAME_CONTROLLER_CLOCK_50  in  1  system clock; all state changes on its rising edge
- CC_GAME_CONTROLLER_RESET_InHigh  in  1  asynchronous, active-high reset
- CC_GAME_CONTROLLER_COLLISION_InLow  in  1  collision flag from the detector; 0 = collision
- CC_GAME_CONTROLLER_START_InLow  in  1  start button, active low, already synchronised/debounced
- CC_GAME_CONTROLLER_TICK_InHigh  in  1  game-step strobe, one clock wide
- CC_GAME_CONTROLLER_RUN_OutHigh  out  1  enables scrolling/movement in the upstream generators
- CC_GAME_CONTROLLER_CLEAR_OutHigh  out  1  one-clock pulse; clears the upstream background matrix
- CC_GAME_CONTROLLER_HIT_OutHigh  out  1  one-clock pulse on every accepted collision
- CC_GAME_CONTROLLER_GAMEOVER_OutHigh  out  1  high while in OVER
- CC_GAME_CONTROLLER_LIVES_OutBUS  out  LIVES_WIDTH  remaining lives
- CC_GAME_CONTROLLER_SCORE_OutBUS  out  SCORE_WIDTH  ticks survived in the current round

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - state = IDLE, RUN = 0, CLEAR = 0, HIT = 0, GAMEOVER = 0
  - LIVES = LIVES_INIT, SCORE = 0, hit counter = 0
  - start_prev = 1 (no press)
- Reset mid-round aborts immediately to the reset values. No pulse is emitted on reset release.
- Start event: a falling edge on START_InLow (start_prev = 1, current = 0). Holding the button low gives exactly one event.
- IDLE:
  - RUN = 0.
  - Start event -> PLAY next cycle. In that same transition edge: CLEAR = 1 for one clock, LIVES = LIVES_INIT, SCORE = 0.
  - TICK and COLLISION are ignored.
- PLAY:
  - RUN = 1.
  - COLLISION is sampled only on cycles where TICK = 1.
  - TICK with COLLISION = 0:
    - HIT pulses for one clock and LIVES decrements by 1.
    - If LIVES was 1: LIVES becomes 0 and state -> OVER.
    - Otherwise: state -> HIT and the hit counter loads HIT_TICKS.
    - SCORE is not incremented on that tick.
  - TICK with COLLISION = 1: SCORE increments by 1, saturating at 2^SCORE_WIDTH-1 (no wrap).
  - Start events are ignored.
- HIT:
  - RUN = 0 (freeze).
  - Each TICK decrements the hit counter.
  - On a TICK with counter = 1: counter becomes 0, state -> PLAY, and CLEAR pulses for one clock on the same edge.
  - COLLISION and start events are ignored.
  - Latency: exactly HIT_TICKS ticks from the hit tick to RUN returning high. RUN rises on the clock after the last frozen tick.
- OVER:
  - GAMEOVER = 1, RUN = 0. LIVES = 0 and SCORE holds its final value.
  - Start event -> PLAY with the same actions as from IDLE; GAMEOVER drops on that edge.
  - If a TICK coincides with the start event, the start wins and the tick is ignored.
- Output relations:
  - RUN = 1 only in PLAY.
  - CLEAR and HIT are never high for two consecutive cycles.
  - HIT and CLEAR are never high in the same cycle.
- COLLISION is combinational from the same clock domain; no synchroniser is required.

Test Plan:
- Reset asserted mid-PLAY with SCORE = 5 -> next observed state IDLE, LIVES = 3, SCORE = 0, RUN = 0, no CLEAR or HIT pulse after release.
- Start pulse (held low 10 clocks) from IDLE -> exactly one CLEAR pulse, RUN = 1; 7 ticks with COLLISION = 1 -> SCORE = 7; COLLISION = 0 between ticks -> no effect.
- In PLAY, tick with COLLISION = 0 -> HIT pulse, LIVES 3 -> 2, RUN = 0. Four further ticks with COLLISION = 0 cause no lives change. The 4th tick produces a CLEAR pulse and RUN = 1 on the next clock.
- Three fatal ticks (LIVES 3 -> 2 -> 1 -> 0, with freezes between) -> GAMEOVER = 1, LIVES = 0, SCORE frozen; further ticks leave everything unchanged.
- In OVER, start event on the same cycle as TICK -> PLAY, LIVES = 3, SCORE = 0, GAMEOVER = 0, one CLEAR pulse, SCORE not incremented.
- SCORE_WIDTH = 4, run 20 clean ticks -> SCORE saturates at 15 and stays at 15.

Source files
------------

// File: rtl/cc_game_controller.sv
// Round controller behind the collision detector: sequences idle/play/hit-freeze/over,
// keeps lives and score, and drives the run enable and clear pulse back to the generators.
module cc_game_controller #(
   parameter int LIVES_INIT  = 3,
   parameter int LIVES_WIDTH = 2,
   parameter int SCORE_WIDTH = 8,
   parameter int HIT_TICKS   = 4
) (
   input  logic                   CC_GAME_CONTROLLER_CLOCK_50,
   input  logic                   CC_GAME_CONTROLLER_RESET_InHigh,
   input  logic                   CC_GAME_CONTROLLER_COLLISION_InLow,
   input  logic                   CC_GAME_CONTROLLER_START_InLow,
   input  logic                   CC_GAME_CONTROLLER_TICK_InHigh,
   output logic                   CC_GAME_CONTROLLER_RUN_OutHigh,
   output logic                   CC_GAME_CONTROLLER_CLEAR_OutHigh,
   output logic                   CC_GAME_CONTROLLER_HIT_OutHigh,
   output logic                   CC_GAME_CONTROLLER_GAMEOVER_OutHigh,
   output logic [LIVES_WIDTH-1:0] CC_GAME_CONTROLLER_LIVES_OutBUS,
   output logic [SCORE_WIDTH-1:0] CC_GAME_CONTROLLER_SCORE_OutBUS
);

   localparam int HIT_WIDTH = $clog2(HIT_TICKS + 1);
   localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);
   localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = {SCORE_WIDTH{1'b1}};
   localparam logic [HIT_WIDTH-1:0]   HIT_LOAD   = HIT_WIDTH'(HIT_TICKS);

   typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} stateT;

   stateT                  state, stateNext;
   logic                   startPrev;
   logic                   startEvent;
   logic [LIVES_WIDTH-1:0] lives, livesNext;
   logic [SCORE_WIDTH-1:0] score, scoreNext;
   logic [HIT_WIDTH-1:0]   hitCnt, hitCntNext;
   logic                   runQ, clearQ, hitQ, overQ;
   logic                   clearNext, hitNext;

   // A press is the falling edge only, so holding the button starts one round.
   assign startEvent = startPrev & ~CC_GAME_CONTROLLER_START_InLow;

   always_comb begin
      stateNext  = state;
      livesNext  = lives;
      scoreNext  = score;
      hitCntNext = hitCnt;
      clearNext  = 1'b0;
      hitNext    = 1'b0;
      case (state)
         IDLE, OVER: begin
            if (startEvent) begin
               stateNext = PLAY;
               clearNext = 1'b1;
               livesNext = LIVES_LOAD;
               scoreNext = '0;
            end
         end
         PLAY: begin
            if (CC_GAME_CONTROLLER_TICK_InHigh) begin
               if (!CC_GAME_CONTROLLER_COLLISION_InLow) begin
                  hitNext   = 1'b1;
                  livesNext = lives - LIVES_WIDTH'(1);
                  if (lives == LIVES_WIDTH'(1)) begin
                     stateNext = OVER;
                  end else begin
                     stateNext  = HIT;
                     hitCntNext = HIT_LOAD;
                  end
               end else if (score != SCORE_MAX) begin
                  scoreNext = score + SCORE_WIDTH'(1);
               end
            end
         end
         HIT: begin
            // The last frozen tick hands back to PLAY with a fresh background.
            if (CC_GAME_CONTROLLER_TICK_InHigh) begin
               hitCntNext = hitCnt - HIT_WIDTH'(1);
               if (hitCnt == HIT_WIDTH'(1)) begin
                  stateNext = PLAY;
                  clearNext = 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CC_GAME_CONTROLLER_CLOCK_50 or posedge CC_GAME_CONTROLLER_RESET_InHigh) begin
      if (CC_GAME_CONTROLLER_RESET_InHigh) begin
         state     <= IDLE;
         startPrev <= 1'b1;
         lives     <= LIVES_LOAD;
         score     <= '0;
         hitCnt    <= '0;
         runQ      <= 1'b0;
         clearQ    <= 1'b0;
         hitQ      <= 1'b0;
         overQ     <= 1'b0;
      end else begin
         state     <= stateNext;
         startPrev <= CC_GAME_CONTROLLER_START_InLow;
         lives     <= livesNext;
         score     <= scoreNext;
         hitCnt    <= hitCntNext;
         runQ      <= (stateNext == PLAY);
         clearQ    <= clearNext;
         hitQ      <= hitNext;
         overQ     <= (stateNext == OVER);
      end
   end

   assign CC_GAME_CONTROLLER_RUN_OutHigh      = runQ;
   assign CC_GAME_CONTROLLER_CLEAR_OutHigh    = clearQ;
   assign CC_GAME_CONTROLLER_HIT_OutHigh      = hitQ;
   assign CC_GAME_CONTROLLER_GAMEOVER_OutHigh = overQ;
   assign CC_GAME_CONTROLLER_LIVES_OutBUS     = lives;
   assign CC_GAME_CONTROLLER_SCORE_OutBUS     = score;

endmodule

// File: tb/tb_cc_game_controller.sv
// Bench for cc_game_controller: directed vector table, hand sequences for reset and
// score saturation, then random play against a rule-level model of a round.
module tb_cc_game_controller;

   localparam int LIVES_INIT = 3;
   localparam int HIT_TICKS  = 4;
   localparam int SCORE_MAX  = 255;
   localparam int SMALL_MAX  = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       collision = 1'b1;
   logic       start = 1'b1;
   logic       tick = 1'b0;
   logic       run, clear, hit, gameOver;
   logic [1:0] lives;
   logic [7:0] score;
   logic       runS, clearS, hitS, gameOverS;
   logic [1:0] livesS;
   logic [3:0] scoreS;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cc_game_controller dut (
      .CC_GAME_CONTROLLER_CLOCK_50        (clk),
      .CC_GAME_CONTROLLER_RESET_InHigh    (rst),
      .CC_GAME_CONTROLLER_COLLISION_InLow (collision),
      .CC_GAME_CONTROLLER_START_InLow     (start),
      .CC_GAME_CONTROLLER_TICK_InHigh     (tick),
      .CC_GAME_CONTROLLER_RUN_OutHigh     (run),
      .CC_GAME_CONTROLLER_CLEAR_OutHigh   (clear),
      .CC_GAME_CONTROLLER_HIT_OutHigh     (hit),
      .CC_GAME_CONTROLLER_GAMEOVER_OutHigh(gameOver),
      .CC_GAME_CONTROLLER_LIVES_OutBUS    (lives),
      .CC_GAME_CONTROLLER_SCORE_OutBUS    (score)
   );

   cc_game_controller #(.SCORE_WIDTH(4)) dutSmall (
      .CC_GAME_CONTROLLER_CLOCK_50        (clk),
      .CC_GAME_CONTROLLER_RESET_InHigh    (rst),
      .CC_GAME_CONTROLLER_COLLISION_InLow (collision),
      .CC_GAME_CONTROLLER_START_InLow     (start),
      .CC_GAME_CONTROLLER_TICK_InHigh     (tick),
      .CC_GAME_CONTROLLER_RUN_OutHigh     (runS),
      .CC_GAME_CONTROLLER_CLEAR_OutHigh   (clearS),
      .CC_GAME_CONTROLLER_HIT_OutHigh     (hitS),
      .CC_GAME_CONTROLLER_GAMEOVER_OutHigh(gameOverS),
      .CC_GAME_CONTROLLER_LIVES_OutBUS    (livesS),
      .CC_GAME_CONTROLLER_SCORE_OutBUS    (scoreS)
   );

   // Rule-level model of a round.
   typedef enum {M_IDLE, M_PLAY, M_FROZEN, M_OVER} modeT;
   modeT mMode;
   int   mLives, mScore, mScoreS, mFrozenLeft;
   bit   mPrevStart, mClear, mHit;

   task automatic modelReset();
      mMode = M_IDLE; mLives = LIVES_INIT; mScore = 0; mScoreS = 0;
      mFrozenLeft = 0; mPrevStart = 1'b1; mClear = 1'b0; mHit = 1'b0;
   endtask

   task automatic modelEdge(input bit s, input bit c, input bit t);
      bit pressed;
      pressed = mPrevStart && !s;
      mPrevStart = s;
      mClear = 1'b0;
      mHit = 1'b0;
      if (mMode == M_IDLE || mMode == M_OVER) begin
         if (pressed) begin
            mMode = M_PLAY; mClear = 1'b1; mLives = LIVES_INIT; mScore = 0; mScoreS = 0;
         end
      end else if (mMode == M_PLAY) begin
         if (t && !c) begin
            mHit = 1'b1;
            mLives = mLives - 1;
            if (mLives == 0) mMode = M_OVER;
            else begin mMode = M_FROZEN; mFrozenLeft = HIT_TICKS; end
         end else if (t) begin
            if (mScore < SCORE_MAX) mScore++;
            if (mScoreS < SMALL_MAX) mScoreS++;
         end
      end else if (t) begin
         mFrozenLeft--;
         if (mFrozenLeft == 0) begin mMode = M_PLAY; mClear = 1'b1; end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic checkModel(input string tag);
      check({tag, " run"},      int'(run),      int'(mMode == M_PLAY));
      check({tag, " clear"},    int'(clear),    int'(mClear));
      check({tag, " hit"},      int'(hit),      int'(mHit));
      check({tag, " gameover"}, int'(gameOver), int'(mMode == M_OVER));
      check({tag, " lives"},    int'(lives),    mLives);
      check({tag, " score"},    int'(score),    mScore);
      check({tag, " runS"},     int'(runS),     int'(mMode == M_PLAY));
      check({tag, " clearS"},   int'(clearS),   int'(mClear));
      check({tag, " hitS"},     int'(hitS),     int'(mHit));
      check({tag, " livesS"},   int'(livesS),   mLives);
      check({tag, " scoreS"},   int'(scoreS),   mScoreS);
   endtask

   // Drive one clock of inputs, advance the model on the edge, settle before checking.
   task automatic step(input bit s, input bit c, input bit t);
      start = s; collision = c; tick = t;
      @(posedge clk);
      modelEdge(s, c, t);
      #1;
   endtask

   typedef struct {
      bit s, c, t;
      bit run, clr, hit, over;
      int lives, score;
   } vecT;
   vecT vecs[$];

   task automatic addVec(input bit s, input bit c, input bit t, input bit r, input bit cl,
                         input bit h, input bit o, input int l, input int sc);
      vecT v;
      v.s = s; v.c = c; v.t = t; v.run = r; v.clr = cl; v.hit = h; v.over = o;
      v.lives = l; v.score = sc;
      vecs.push_back(v);
   endtask

   initial begin
      bit prevTick;
      //      s  c  t  run clr hit ovr lives score
      addVec(1, 1, 0, 0,  0,  0,  0,  3,    0);  // idle
      addVec(0, 1, 1, 1,  1,  0,  0,  3,    0);  // press; tick ignored in idle
      addVec(0, 1, 0, 1,  0,  0,  0,  3,    0);  // held low: no second clear
      addVec(0, 1, 1, 1,  0,  0,  0,  3,    1);
      addVec(1, 1, 1, 1,  0,  0,  0,  3,    2);
      addVec(1, 0, 0, 1,  0,  0,  0,  3,    2);  // collision between ticks ignored
      addVec(1, 1, 1, 1,  0,  0,  0,  3,    3);
      addVec(0, 1, 1, 1,  0,  0,  0,  3,    4);  // press during play ignored
      addVec(1, 0, 1, 0,  0,  1,  0,  2,    4);  // hit
      addVec(1, 0, 0, 0,  0,  0,  0,  2,    4);
      addVec(1, 0, 1, 0,  0,  0,  0,  2,    4);  // frozen tick 1
      addVec(0, 0, 1, 0,  0,  0,  0,  2,    4);  // frozen tick 2, press ignored
      addVec(1, 0, 1, 0,  0,  0,  0,  2,    4);  // frozen tick 3
      addVec(1, 0, 0, 0,  0,  0,  0,  2,    4);
      addVec(1, 0, 1, 1,  1,  0,  0,  2,    4);  // frozen tick 4 -> resume
      addVec(1, 1, 1, 1,  0,  0,  0,  2,    5);
      addVec(1, 0, 1, 0,  0,  1,  0,  1,    5);  // second hit
      addVec(1, 1, 1, 0,  0,  0,  0,  1,    5);
      addVec(1, 1, 1, 0,  0,  0,  0,  1,    5);
      addVec(1, 1, 1, 0,  0,  0,  0,  1,    5);
      addVec(1, 1, 1, 1,  1,  0,  0,  1,    5);
      addVec(1, 0, 1, 0,  0,  1,  1,  0,    5);  // fatal hit
      addVec(1, 0, 1, 0,  0,  0,  1,  0,    5);
      addVec(1, 1, 1, 0,  0,  0,  1,  0,    5);
      addVec(0, 1, 1, 1,  1,  0,  0,  3,    0);  // press with tick in over
      addVec(0, 1, 0, 1,  0,  0,  0,  3,    0);
      addVec(1, 1, 1, 1,  0,  0,  0,  3,    1);

      // Clock/reset
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkModel("reset");
      check("reset lives const", int'(lives), 3);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].s, vecs[i].c, vecs[i].t);
         check($sformatf("vec%0d run", i),      int'(run),      int'(vecs[i].run));
         check($sformatf("vec%0d clear", i),    int'(clear),    int'(vecs[i].clr));
         check($sformatf("vec%0d hit", i),      int'(hit),      int'(vecs[i].hit));
         check($sformatf("vec%0d gameover", i), int'(gameOver), int'(vecs[i].over));
         check($sformatf("vec%0d lives", i),    int'(lives),    vecs[i].lives);
         check($sformatf("vec%0d score", i),    int'(score),    vecs[i].score);
         check($sformatf("vec%0d scoreS", i),   int'(scoreS),   vecs[i].score);
      end

      // Reset in the middle of a round with score 5
      repeat (4) begin
         step(1, 1, 1);
         step(1, 1, 0);
      end
      check("midreset score before", int'(score), 5);
      rst = 1'b1;
      #1;
      modelReset();
      check("midreset async run", int'(run), 0);
      check("midreset async score", int'(score), 0);
      check("midreset async lives", int'(lives), 3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1);
         checkModel($sformatf("postreset%0d", i));
         check($sformatf("postreset%0d clear const", i), int'(clear | hit), 0);
      end

      // Saturation: 20 clean ticks
      step(0, 1, 0);
      checkModel("sat start");
      step(1, 1, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 1);
         checkModel($sformatf("sat%0d", i));
         step(1, 1, 0);
      end
      check("sat score wide", int'(score), 20);
      check("sat score small", int'(scoreS), 15);
      step(1, 1, 1);
      check("sat score small hold", int'(scoreS), 15);

      // Random play against the model
      prevTick = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         bit s, c, t;
         s = ($urandom_range(0, 9) != 0);
         c = ($urandom_range(0, 3) != 0);
         t = prevTick ? 1'b0 : ($urandom_range(0, 2) == 0);
         prevTick = t;
         step(s, c, t);
         checkModel($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
